// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: FSM state encoding and Booth pair codes.
package mdu_pkg;
  typedef enum logic [2:0] {IDLE, MULT, DIV, FIXUP, DONE} mdu_state_e;

  localparam logic [1:0] BOOTH_HOLD0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD   = 2'b01;
  localparam logic [1:0] BOOTH_SUB   = 2'b10;
  localparam logic [1:0] BOOTH_HOLD1 = 2'b11;
endpackage

// File: rtl/mdu_if.sv
// Control FSM <-> multiply/divide unit bus: start pulses with operands, done/status and HI/LO results.
interface mdu_if #(parameter int WIDTH = 32);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             result_is_div;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;

  modport master (output start_mult, start_div, op_a, op_b,
                  input  busy, done, div_zero, result_is_div, result_hi, result_lo);
  modport slave  (input  start_mult, start_div, op_a, op_b,
                  output busy, done, div_zero, result_is_div, result_hi, result_lo);
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next dividend bit,
// subtract the divisor when it fits and report the resulting quotient bit.
module mdu_div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q_bit
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_q_bit = ~w_diff[WIDTH];
  assign o_rem   = o_q_bit ? w_diff : w_shift;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed Booth multiplier / restoring divider producing HI/LO for the multicycle CPU.
// Optional MDU_ABORT_EN adds an abort input that cancels a running operation.
module mult_div_unit
  import mdu_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic clock,
  input  logic reset,
`ifdef MDU_ABORT_EN
  input  logic abort,
`endif
  mdu_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_hi;      // one guard bit so adding/subtracting MIN_INT cannot overflow
  logic [WIDTH-1:0] r_lo;
  logic             r_qm1;
  logic [WIDTH-1:0] r_m;
  logic             r_op_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;
  logic             r_res_div;

  logic             w_abort;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_div_rem;
  logic             w_div_qbit;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

`ifdef MDU_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_m_ext = {r_m[WIDTH-1], r_m};
  assign w_abs_a = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
  assign w_abs_b = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;

  always_comb begin
    w_booth_sum = r_hi;
    case ({r_lo[0], r_qm1})
      BOOTH_ADD: w_booth_sum = r_hi + w_m_ext;
      BOOTH_SUB: w_booth_sum = r_hi - w_m_ext;
      default:   w_booth_sum = r_hi;
    endcase
  end

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem     (r_hi),
    .i_quo     (r_lo),
    .i_divisor (r_m),
    .o_rem     (w_div_rem),
    .o_q_bit   (w_div_qbit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_qm1     <= 1'b0;
      r_m       <= '0;
      r_op_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      r_res_hi  <= '0;
      r_res_lo  <= '0;
      r_res_div <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= CNT_W'(WIDTH - 1);
          r_hi  <= '0;
          r_qm1 <= 1'b0;
          r_dz  <= 1'b0;
          if (bus.start_mult) begin
            r_lo     <= bus.op_b;
            r_m      <= bus.op_a;
            r_op_div <= 1'b0;
            r_state  <= MULT;
          end else if (bus.start_div) begin
            if (bus.op_b == '0) begin
              r_dz      <= 1'b1;
              r_res_div <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_lo     <= w_abs_a;
              r_m      <= w_abs_b;
              r_op_div <= 1'b1;
              r_neg_q  <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
              r_neg_r  <= bus.op_a[WIDTH-1];
              r_state  <= DIV;
            end
          end
        end
        MULT: begin
          if (w_abort) r_state <= IDLE;
          else begin
            r_hi  <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
            r_lo  <= {w_booth_sum[0], r_lo[WIDTH-1:1]};
            r_qm1 <= r_lo[0];
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) r_state <= FIXUP;
          end
        end
        DIV: begin
          if (w_abort) r_state <= IDLE;
          else begin
            r_hi  <= w_div_rem;
            r_lo  <= {r_lo[WIDTH-2:0], w_div_qbit};
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) r_state <= FIXUP;
          end
        end
        FIXUP: begin
          if (w_abort) r_state <= IDLE;
          else begin
            // truncating division: quotient sign from operand signs, remainder follows dividend
            r_res_hi  <= (r_op_div && r_neg_r) ? -r_hi[WIDTH-1:0] : r_hi[WIDTH-1:0];
            r_res_lo  <= (r_op_div && r_neg_q) ? -r_lo : r_lo;
            r_res_div <= r_op_div;
            r_state   <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = (r_state != IDLE);
  assign bus.done          = (r_state == DONE);
  assign bus.div_zero      = (r_state == DONE) && r_dz;
  assign bus.result_is_div = r_res_div;
  assign bus.result_hi     = r_res_hi;
  assign bus.result_lo     = r_res_lo;
endmodule
